// File: rtl/cam_match_array.sv
// 32-entry CAM match array: key/valid storage plus a registered match vector with valid/ready toward the encoder.
// Optional ternary masking is enabled by defining CAM_MATCH_TERNARY_EN.
module cam_match_array #(
    parameter int unsigned KEY_W = 16,
    parameter int unsigned DEPTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [4:0]       wr_addr_i,
    input  logic [KEY_W-1:0] wr_key_i,
`ifdef CAM_MATCH_TERNARY_EN
    input  logic [KEY_W-1:0] wr_mask_i,
`endif
    input  logic             inval_en_i,
    input  logic [4:0]       inval_addr_i,
    input  logic             flush_i,
    input  logic             srch_req_i,
    input  logic [KEY_W-1:0] srch_key_i,
    output logic             srch_rdy_o,
    output logic [31:0]      match_o,
    output logic             match_valid_o,
    input  logic             down_rdy_i,
    output logic [5:0]       entry_cnt_o
);

    localparam int unsigned CNT_W = 6;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HELD  = 1'b1
    } out_state_e;

    out_state_e             state_q, state_d;
    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [KEY_W-1:0]       key_q [DEPTH];
    logic [KEY_W-1:0]       key_d [DEPTH];
    logic [31:0]            match_q, match_d;
    logic [CNT_W-1:0]       entry_cnt_q, entry_cnt_d;
    logic [DEPTH-1:0]       hit;
    logic                   accept;
    logic                   wr_eff;

`ifdef CAM_MATCH_TERNARY_EN
    logic [KEY_W-1:0]       mask_q [DEPTH];
    logic [KEY_W-1:0]       mask_d [DEPTH];
`endif

    assign srch_rdy_o    = (state_q == ST_EMPTY) || down_rdy_i;
    assign accept        = srch_req_i && srch_rdy_o;
    assign match_o       = match_q;
    assign match_valid_o = (state_q == ST_HELD);
    assign entry_cnt_o   = entry_cnt_q;

    // Flush suppresses any write or invalidate issued in the same cycle.
    assign wr_eff = wr_en_i && !flush_i;

    // Storage next-state: flush > write > invalidate.
    always_comb begin
        valid_d = valid_q;
        key_d   = key_q;
`ifdef CAM_MATCH_TERNARY_EN
        mask_d  = mask_q;
`endif
        if (flush_i) begin
            valid_d = '0;
        end else begin
            if (inval_en_i) begin
                valid_d[inval_addr_i] = 1'b0;
            end
            if (wr_en_i) begin
                valid_d[wr_addr_i] = 1'b1;
            end
        end
        if (wr_eff) begin
            key_d[wr_addr_i] = wr_key_i;
`ifdef CAM_MATCH_TERNARY_EN
            mask_d[wr_addr_i] = wr_mask_i;
`endif
        end
    end

    // Hit evaluation uses pre-edge contents, so concurrent updates are seen by the next search.
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef CAM_MATCH_TERNARY_EN
            hit[i] = valid_q[i] && (((key_q[i] ^ srch_key_i) & ~mask_q[i]) == '0);
`else
            hit[i] = valid_q[i] && (key_q[i] == srch_key_i);
`endif
        end
    end

    // Popcount of the current valid bits, registered one cycle behind them.
    always_comb begin
        entry_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_cnt_d = entry_cnt_d + CNT_W'(valid_q[i]);
        end
    end

    // Output register FSM: result held until the consumer takes it.
    always_comb begin
        state_d = state_q;
        match_d = match_q;
        if (accept) begin
            match_d = 32'(hit);
        end
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (down_rdy_i && !accept) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_EMPTY;
            valid_q     <= '0;
            match_q     <= '0;
            entry_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            match_q     <= match_d;
            entry_cnt_q <= entry_cnt_d;
        end
    end

    // Key storage needs no reset; valid bits gate every hit.
    always_ff @(posedge clk_i) begin
        key_q <= key_d;
    end

`ifdef CAM_MATCH_TERNARY_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mask_q[i] <= '0;
            end
        end else begin
            mask_q <= mask_d;
        end
    end
`endif

endmodule

// File: doc/cam_match_array.md
Name: cam_match_array

Overview:
- 32-entry content-addressable match array with search/store.
- Sits directly upstream of the 32:5 priority encoder in the CAM path.
- Stores keys with per-entry valid bits and accepts one search per cycle.
- Produces a registered 32-bit one-hot-or-multi-hot match vector (bit i = entry i hit) with a valid/ready handshake toward the encoder stage.

Parameters:
- KEY_W, 16, key width in bits (1..64).
- DEPTH, 32, entry count; fixed at 32 to match the 32-bit encoder input; other values are unsupported.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- wr_en_i  input  1  write entry wr_addr_i with wr_key_i and set its valid bit.
- wr_addr_i  input  5  write index.
- wr_key_i  input  KEY_W  key to store.
- inval_en_i  input  1  clear valid bit of entry inval_addr_i.
- inval_addr_i  input  5  invalidate index.
- flush_i  input  1  clear all valid bits.
- srch_req_i  input  1  search request; accepted when srch_req_i && srch_rdy_o.
- srch_key_i  input  KEY_W  search key.
- srch_rdy_o  output  1  array can accept a search this cycle.
- match_o  output  32  registered match vector.
- match_valid_o  output  1  match_o holds an unconsumed result.
- down_rdy_i  input  1  downstream (encoder/consumer) accepts match_o.
- entry_cnt_o  output  6  registered count of valid entries (0..32).

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream): all valid bits 0, key storage don't-care, match_o=0, match_valid_o=0, entry_cnt_o=0. srch_rdy_o=1 whenever out of reset.
- Entry i hits when valid[i]=1 and key[i]==srch_key_i (all KEY_W bits).
- Search latency: 1 cycle. Accepted search at edge N → match_o/match_valid_o valid after edge N.
- Output register states: EMPTY (match_valid_o=0) and HELD (match_valid_o=1).
  - EMPTY + accept → HELD.
  - HELD + down_rdy_i + accept → HELD with new result.
  - HELD + down_rdy_i + no accept → EMPTY; match_o keeps its last value.
  - HELD + !down_rdy_i → HELD; match_o frozen.
- srch_rdy_o = !match_valid_o || down_rdy_i, combinational. srch_req_i while !srch_rdy_o is ignored; no queueing.
- No-hit result: match_o=0 with match_valid_o=1. The downstream encoder reports valid=0.
- Storage update priority in one cycle: flush_i > wr_en_i > inval_en_i.
  - flush_i alone clears all valid bits and suppresses any write or invalidate that cycle.
  - Write and invalidate to the same index: the write wins and the entry ends valid.
  - Write and invalidate to different indices: both take effect.
- Search concurrent with any update: the search sees contents before the edge (read-before-write). The new key or valid state is visible from the next search.
- A write to an already-valid entry overwrites its key. entry_cnt_o is unchanged.
- entry_cnt_o updates one cycle after the valid-bit change and equals the popcount of the valid bits. It never exceeds 32 and has no wrap.
- Reset asserted mid-operation: a pending HELD result is dropped immediately. No result is emitted after reset releases until a new search is accepted.
- Duplicate keys are legal and produce multiple bits set in match_o. Resolution is the downstream encoder's job (lowest index wins).

Optional Feature:
- Macro: CAM_MATCH_TERNARY_EN.
- Defined:
  - Adds input wr_mask_i [KEY_W], stored per entry alongside the key.
  - A mask bit of 1 makes that key bit don't-care for hit evaluation.
  - Mask bits are written together with the key under the same priority rules.
  - Reset clears all masks to 0.
- Undefined: no mask storage and no wr_mask_i port; match is exact on all KEY_W bits.

Test Plan:
- Reset then search key 0x1234 → match_o=0x00000000, match_valid_o=1 after 1 cycle, entry_cnt_o=0.
- Write entry 5 = 0xBEEF, next cycle search 0xBEEF → match_o=0x00000020, entry_cnt_o=1.
- Write entries 3 and 17 = 0x00AA, search 0x00AA → match_o=0x00020008. Then invalidate 3 and search again → match_o=0x00020000, entry_cnt_o=1.
- Write entry 9 = 0x5555 and search 0x5555 in the same cycle → match_o bit 9 = 0. Repeat the search next cycle → bit 9 = 1.
- Search accepted with down_rdy_i=0 for 3 cycles → match_o/match_valid_o stable and srch_rdy_o=0. A new srch_req_i in that window is dropped. Raise down_rdy_i → EMPTY the next cycle.
- Fill all 32 entries, assert flush_i together with wr_en_i to entry 0 → all valid bits 0 and entry_cnt_o goes 32→0. Then assert rst_ni low while HELD → match_valid_o=0 immediately.
